// File: rtl/data_mem_responder.sv
// Multi-cycle data RAM responder for load/store requests over valid/ready request and response channels.
// Optional range checking is enabled with `define DMEM_BOUNDS_CHECK_EN.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | ready for a request (MEM_req_ready=1)
// ST_WAIT | aligned access pending, counting down the access cycles
// ST_RESP | response registered and held until MEM_resp_ready
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic        MEM_req_valid,
  output logic        MEM_req_ready,
  input  logic        MEM_req_write,
  input  logic [1:0]  MEM_length,
  input  logic        MEM_read_signed,
  input  logic [31:0] MEM_address,
  input  logic [31:0] MEM_write_data,
  output logic        MEM_resp_valid,
  input  logic        MEM_resp_ready,
  output logic [31:0] MEM_read_data,
  output logic        MEM_error
);

  localparam int AW = $clog2(DEPTH_WORDS);
`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  localparam logic [1:0] LEN_NONE = 2'b00;
  localparam logic [1:0] LEN_BYTE = 2'b01;
  localparam logic [1:0] LEN_HALF = 2'b10;
  localparam logic [1:0] LEN_WORD = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t       state;
  logic [31:0]  mem [DEPTH_WORDS];
  logic         lat_write;
  logic [1:0]   lat_len;
  logic         lat_signed;
  logic [AW+1:0] lat_addr;
  logic [31:0]  lat_wdata;
  logic [3:0]   wait_cnt;

  logic          accept;
  logic          misaligned;
  logic          addr_hi_nz;
  logic          req_bad;
  logic          finish_wait;
  logic          ram_we;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_data;
  logic [3:0]    be;
  logic [31:0]   wd_lanes;

  assign accept      = (state == ST_IDLE) && MEM_req_valid && MEM_req_ready;
  assign misaligned  = ((MEM_length == LEN_HALF) && MEM_address[0]) ||
                       ((MEM_length == LEN_WORD) && (MEM_address[1:0] != 2'b00));
  assign addr_hi_nz  = (MEM_address >> (AW + 2)) != 32'd0;
  assign req_bad     = misaligned | (BOUNDS_EN & addr_hi_nz);
  assign finish_wait = (state == ST_WAIT) && (wait_cnt == 4'd0);
  assign ram_we      = finish_wait && lat_write && (lat_len != LEN_NONE);
  assign word_idx    = lat_addr[AW+1:2];
  assign rd_word     = mem[word_idx];
  assign rd_byte     = rd_word[{lat_addr[1:0], 3'b000} +: 8];
  assign rd_half     = rd_word[{lat_addr[1], 4'b0000} +: 16];

  always_comb begin
    load_data = 32'd0;
    if (!lat_write) begin
      case (lat_len)
        LEN_BYTE: load_data = {{24{lat_signed & rd_byte[7]}}, rd_byte};
        LEN_HALF: load_data = {{16{lat_signed & rd_half[15]}}, rd_half};
        LEN_WORD: load_data = rd_word;
        default:  load_data = 32'd0;
      endcase
    end
  end

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    be       = 4'b0000;
    wd_lanes = lat_wdata;
    case (lat_len)
      LEN_BYTE: begin
        be       = 4'b0001 << lat_addr[1:0];
        wd_lanes = {4{lat_wdata[7:0]}};
      end
      LEN_HALF: begin
        be       = lat_addr[1] ? 4'b1100 : 4'b0011;
        wd_lanes = {2{lat_wdata[15:0]}};
      end
      LEN_WORD: be = 4'b1111;
      default:  be = 4'b0000;
    endcase
  end

  always_ff @(posedge SYS_clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wd_lanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      state          <= ST_IDLE;
      MEM_req_ready  <= 1'b1;
      MEM_resp_valid <= 1'b0;
      MEM_read_data  <= 32'd0;
      MEM_error      <= 1'b0;
      wait_cnt       <= 4'd0;
      lat_write      <= 1'b0;
      lat_len        <= LEN_NONE;
      lat_signed     <= 1'b0;
      lat_addr       <= '0;
      lat_wdata      <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lat_write     <= MEM_req_write;
            lat_len       <= MEM_length;
            lat_signed    <= MEM_read_signed;
            lat_addr      <= MEM_address[AW+1:0];
            lat_wdata     <= MEM_write_data;
            MEM_req_ready <= 1'b0;
            if (req_bad) begin
              state          <= ST_RESP;
              MEM_resp_valid <= 1'b1;
              MEM_read_data  <= 32'd0;
              MEM_error      <= 1'b1;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= 4'(WAIT_CYCLES);
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state          <= ST_RESP;
            MEM_resp_valid <= 1'b1;
            MEM_read_data  <= load_data;
            MEM_error      <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (MEM_resp_ready) begin
            state          <= ST_IDLE;
            MEM_resp_valid <= 1'b0;
            MEM_req_ready  <= 1'b1;
          end
        end
        default: begin
          state          <= ST_IDLE;
          MEM_resp_valid <= 1'b0;
          MEM_req_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
